// File: rtl/abs_diff_mon_pkg.sv
// Shared definitions for the abs_diff sweep monitor: FSM state codes, sweep sizing
// and the reference |A-B| used to score each netlist response.
package abs_diff_mon_pkg;

  localparam int IN_W_DEF  = 8;
  localparam int N_VEC     = 2 ** IN_W_DEF;
  localparam int DRAIN_CYC = 2;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic [15:0] exact_abs_diff(input logic [15:0] a, input logic [15:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/abs_diff_err_acc.sv
// S2 of the monitor: scores one registered netlist response against the exact
// |A-B| and folds the error into the max / sum / violation accumulators.
module abs_diff_err_acc
  import abs_diff_mon_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 5,
  parameter int ET    = 16,
  parameter int SUM_W = IN_W + OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             valid,
  input  logic [IN_W-1:0]  vec,
  input  logic [OUT_W-1:0] resp,
  output logic [OUT_W:0]   max_err,
  output logic [SUM_W-1:0] sum_err,
  output logic [IN_W:0]    viol_cnt
);

  localparam int HALF = IN_W / 2;

  logic [HALF-1:0] op_a;
  logic [HALF-1:0] op_b;
  logic [OUT_W:0]  exact;
  logic [OUT_W:0]  resp_ext;
  logic [OUT_W:0]  err;

  assign op_a     = vec[HALF-1:0];
  assign op_b     = vec[IN_W-1:HALF];
  assign exact    = (OUT_W+1)'(exact_abs_diff(16'(op_a), 16'(op_b)));
  assign resp_ext = {1'b0, resp};
  assign err      = (resp_ext >= exact) ? (resp_ext - exact) : (exact - resp_ext);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_err  <= '0;
      sum_err  <= '0;
      viol_cnt <= '0;
    end else if (clear) begin
      max_err  <= '0;
      sum_err  <= '0;
      viol_cnt <= '0;
    end else if (valid) begin
      if (err > max_err) max_err <= err;
      sum_err <= sum_err + SUM_W'(err);
      if (int'(err) > ET) viol_cnt <= viol_cnt + (IN_W+1)'(1);
    end
  end

endmodule

// File: rtl/abs_diff_sweep_monitor.sv
// Exhaustive stimulus/checker around a combinational approximate abs_diff netlist:
// sweeps every operand pair, scores each response and reports pass/fail against ET.
module abs_diff_sweep_monitor
  import abs_diff_mon_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = 5,
  parameter int ET    = 16,
  parameter int SUM_W = IN_W + OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic [OUT_W:0]   max_err,
  output logic [SUM_W-1:0] sum_err,
  output logic [IN_W:0]    viol_cnt,
  output logic             pass
);

  localparam int LAST_IDX = (IN_W == IN_W_DEF) ? (N_VEC - 1) : ((2 ** IN_W) - 1);
  localparam logic [IN_W-1:0] LAST_VEC = IN_W'(LAST_IDX);

  state_t          state;
  logic [IN_W-1:0] vec;
  logic [1:0]      drain_cnt;
  logic            s0_valid;
  logic            s1_valid;
  logic [IN_W-1:0] s1_vec;
  logic [OUT_W-1:0] s1_resp;
  logic            pass_q;
  logic            start_ok;

  assign start_ok = start && !abort && ((state == ST_IDLE) || (state == ST_DONE));

  // The sweep ends on the terminal vector having been presented, so vec never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      vec       <= '0;
      dut_in    <= '0;
      drain_cnt <= '0;
      s0_valid  <= 1'b0;
      pass_q    <= 1'b0;
    end else if (abort) begin
      state    <= ST_IDLE;
      s0_valid <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state    <= ST_SWEEP;
            vec      <= '0;
            s0_valid <= 1'b0;
            pass_q   <= 1'b0;
          end
        end
        ST_SWEEP: begin
          if (s0_valid && (dut_in == LAST_VEC)) begin
            state     <= ST_DRAIN;
            s0_valid  <= 1'b0;
            drain_cnt <= '0;
          end else begin
            dut_in   <= vec;
            s0_valid <= 1'b1;
            if (vec != LAST_VEC) vec <= vec + IN_W'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 2'(DRAIN_CYC - 1)) begin
            state  <= ST_DONE;
            pass_q <= (viol_cnt == '0);
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // S1 gives the netlist a full cycle between the dut_in register and capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_vec   <= '0;
      s1_resp  <= '0;
    end else begin
      s1_valid <= s0_valid && !abort;
      s1_vec   <= dut_in;
      s1_resp  <= dut_out;
    end
  end

  abs_diff_err_acc #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .ET    (ET),
    .SUM_W (SUM_W)
  ) u_err_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_ok),
    .valid    (s1_valid),
    .vec      (s1_vec),
    .resp     (s1_resp),
    .max_err  (max_err),
    .sum_err  (sum_err),
    .viol_cnt (viol_cnt)
  );

  assign busy = (state == ST_SWEEP) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);
  assign pass = pass_q;

endmodule

// File: tb/tb_abs_diff_sweep_monitor.sv
// Directed bench for abs_diff_sweep_monitor: two monitors (ET=16 and ET=7) watch
// bench-modelled netlists and are scored against an operand-level error model.
module tb_abs_diff_sweep_monitor;
  import abs_diff_mon_pkg::*;

  localparam int IN_W  = 8;
  localparam int OUT_W = 5;
  localparam int SUM_W = IN_W + OUT_W;

  logic clk = 1'b0;
  logic rst_n;
  logic start = 1'b0;
  logic abort = 1'b0;

  logic [IN_W-1:0]  dut_in, dut_in_lo;
  logic [OUT_W-1:0] dut_out, dut_out_lo;
  logic             busy, busy_lo, done, done_lo, pass, pass_lo;
  logic [OUT_W:0]   max_err, max_err_lo;
  logic [SUM_W-1:0] sum_err, sum_err_lo;
  logic [IN_W:0]    viol_cnt, viol_cnt_lo;

  int net_mode = 0;
  int checks = 0;
  int errors = 0;
  int k = 0;
  bit track = 1'b0;
  int exp_max, exp_sum, exp_viol, exp_viol_lo;

  always #5 clk = ~clk;

  // Netlist under qualification: 0 exact, 1 constant zero, 2 exact with (A=3,B=12)
  // corrupted to 0, 3 approximate with the two LSBs of the result dropped.
  function automatic logic [OUT_W-1:0] net_fn(input int mode, input logic [IN_W-1:0] din);
    int a, b, d;
    a = int'(din[3:0]);
    b = int'(din[7:4]);
    d = (a > b) ? a - b : b - a;
    case (mode)
      0: return 5'(d);
      1: return 5'd0;
      2: return (a == 3 && b == 12) ? 5'd0 : 5'(d);
      default: return 5'(d & ~3);
    endcase
  endfunction

  assign dut_out    = net_fn(net_mode, dut_in);
  assign dut_out_lo = net_fn(net_mode, dut_in_lo);

  abs_diff_sweep_monitor #(.IN_W(IN_W), .OUT_W(OUT_W), .ET(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
    .max_err(max_err), .sum_err(sum_err), .viol_cnt(viol_cnt), .pass(pass)
  );

  abs_diff_sweep_monitor #(.IN_W(IN_W), .OUT_W(OUT_W), .ET(7)) u_dut_lo (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .dut_in(dut_in_lo), .dut_out(dut_out_lo), .busy(busy_lo), .done(done_lo),
    .max_err(max_err_lo), .sum_err(sum_err_lo), .viol_cnt(viol_cnt_lo), .pass(pass_lo)
  );

  task automatic check_output(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Error statistics over every operand pair, straight from |net - |A-B||.
  task automatic compute_model(input int mode);
    int e, r, x;
    exp_max = 0; exp_sum = 0; exp_viol = 0; exp_viol_lo = 0;
    for (int b = 0; b < 16; b++) begin
      for (int a = 0; a < 16; a++) begin
        r = int'(net_fn(mode, IN_W'(b * 16 + a)));
        x = (a > b) ? a - b : b - a;
        e = (r > x) ? r - x : x - r;
        if (e > exp_max) exp_max = e;
        exp_sum += e;
        if (e > 16) exp_viol++;
        if (e > 7) exp_viol_lo++;
      end
    end
  endtask

  // k counts rising edges since the edge that sampled start; checked every cycle.
  always @(negedge clk) begin
    if (track) begin
      check_output("busy", busy, (k <= 258));
      check_output("done", done, (k >= 259));
      check_output("done_lo", done_lo, (k >= 259));
      if (k < 259) check_output("pass_before_done", pass, 0);
      if (k >= 1 && k <= 256) check_output("dut_in_seq", dut_in, k - 1);
      if (k >= 259) begin
        check_output("max_err", max_err, exp_max);
        check_output("sum_err", sum_err, exp_sum);
        check_output("viol_cnt", viol_cnt, exp_viol);
        check_output("pass", pass, (exp_viol == 0));
        check_output("viol_cnt_lo", viol_cnt_lo, exp_viol_lo);
        check_output("pass_lo", pass_lo, (exp_viol_lo == 0));
      end
      k++;
    end
  end

  task automatic apply_stimulus(input int mode, input bit mid_start);
    net_mode = mode;
    compute_model(mode);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    k = 0;
    track = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 400 && k < 262; i++) begin
      @(negedge clk);
      start = (mid_start && k == 100);
    end
    if (k < 262) check_output("sweep_timeout", k, 262);
    track = 1'b0;
    start = 1'b0;
  endtask

  task automatic begin_manual_sweep(input int mode, input int cycles);
    net_mode = mode;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_dut_in", dut_in, 0);
    check_output("rst_max_err", max_err, 0);
    check_output("rst_sum_err", sum_err, 0);
    check_output("rst_viol_cnt", viol_cnt, 0);
    check_output("rst_pass", pass, 0);
    rst_n = 1'b1;

    apply_stimulus(0, 1'b0);
    check_output("exact_max_lit", max_err, 0);
    check_output("exact_sum_lit", sum_err, 0);
    check_output("exact_viol_lit", viol_cnt, 0);
    check_output("exact_pass_lit", pass, 1);

    apply_stimulus(1, 1'b1);
    check_output("zero_max_lit", max_err, 15);
    check_output("zero_sum_lit", sum_err, 1360);
    check_output("zero_viol_lit", viol_cnt, 0);
    check_output("zero_pass_lit", pass, 1);
    check_output("zero_viol_lo_lit", viol_cnt_lo, 72);
    check_output("zero_pass_lo_lit", pass_lo, 0);

    begin_manual_sweep(1, 50);
    check_output("pre_rst_dut_in", dut_in, 49);
    rst_n = 1'b0;
    #1;
    check_output("midrst_busy", busy, 0);
    check_output("midrst_done", done, 0);
    check_output("midrst_dut_in", dut_in, 0);
    check_output("midrst_max_err", max_err, 0);
    check_output("midrst_sum_err", sum_err, 0);
    check_output("midrst_viol_cnt", viol_cnt, 0);
    check_output("midrst_pass", pass, 0);
    @(negedge clk) rst_n = 1'b1;

    apply_stimulus(2, 1'b0);
    check_output("corrupt_max_lit", max_err, 9);
    check_output("corrupt_sum_lit", sum_err, 9);
    check_output("corrupt_viol_lit", viol_cnt, 0);
    check_output("corrupt_viol_lo_lit", viol_cnt_lo, 1);

    begin_manual_sweep(0, 99);
    check_output("pre_abort_dut_in", dut_in, 98);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    check_output("abort_busy", busy, 0);
    check_output("abort_done", done, 0);
    check_output("abort_dut_in", dut_in, 98);
    repeat (3) @(negedge clk);
    check_output("abort_hold_dut_in", dut_in, 98);
    check_output("abort_hold_busy", busy, 0);

    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_output("start_abort_busy", busy, 0);
    check_output("start_abort_done", done, 0);

    apply_stimulus(0, 1'b0);

    apply_stimulus(3, 1'b0);
    check_output("approx_pass_lit", pass, 1);
    check_output("approx_max_le_et", (max_err <= 16), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/abs_diff_sweep_monitor.md
Name: abs_diff_sweep_monitor

Overview:
Sequential stimulus/checker stage wrapped around one combinational approximate abs_diff netlist (8 inputs, up to 5 outputs).
- Upstream side: drives the netlist inputs with an exhaustive sweep of all operand pairs.
- Downstream side: captures the netlist outputs and compares each against the exact |A-B|.
- Accumulates max error, error sum and error-threshold violations, then reports pass/fail against ET.
- Used on-chip/FPGA to qualify each approximation iteration against its error bound.

Parameters:
- IN_W, 8, total netlist input width; operand A = dut_in[IN_W/2-1:0] (bit0 = in0), operand B = dut_in[IN_W-1:IN_W/2].
- OUT_W, 5, netlist output width; narrower netlists are zero-extended at instantiation.
- ET, 16, error threshold; a vector violates when err > ET.
- SUM_W, IN_W+OUT_W, width of the error-sum accumulator; cannot overflow.

Ports:
- clk, in, 1, single clock; all state on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle request to begin a sweep; accepted only in IDLE or DONE.
- abort, in, 1, terminates sweep; returns to IDLE, results invalid.
- dut_in, out, IN_W, registered stimulus to netlist inputs in0..in(IN_W-1).
- dut_out, in, OUT_W, combinational netlist response (out0 = bit0).
- busy, out, 1, high in SWEEP/DRAIN.
- done, out, 1, level, high in DONE until next accepted start or reset.
- max_err, out, OUT_W+1, largest |dut_out - exact| seen.
- sum_err, out, SUM_W, sum of |dut_out - exact| over all vectors.
- viol_cnt, out, IN_W+1, count of vectors with err > ET.
- pass, out, 1, valid when done; 1 iff viol_cnt == 0.

Behaviour:
- Reset (async assert, sync deassert handled outside): state IDLE; dut_in=0, busy=0, done=0, max_err=0, sum_err=0, viol_cnt=0, pass=0; pipeline valids cleared.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
  - IDLE/DONE + start: clear accumulators, vec=0, go to SWEEP.
  - SWEEP: vec increments every cycle; dut_in = vec. After vec = 2^IN_W-1 is presented, go to DRAIN.
  - DRAIN: 2 cycles, emptying the pipeline, then DONE.
  - DONE: holds results until the next start.
- Pipeline:
  - S0: dut_in register.
  - S1: registers {dut_in, dut_out, v}, i.e. the netlist is given one full cycle.
  - S2: computes exact = |A-B| (OUT_W+1 bits, unsigned compare-subtract), err = |dut_out - exact|, then updates the accumulators.
- Latency: done rises exactly 2^IN_W + 3 cycles after the cycle start is sampled (259 for IN_W=8).
- Width rules: dut_out is zero-extended to OUT_W+1 bits; all arithmetic is unsigned; sum_err is sized to never wrap; viol_cnt reaches 2^IN_W max.
- Boundary conditions:
  - start while busy: ignored.
  - start and abort in the same cycle: abort wins.
  - abort in any state: IDLE next cycle, busy=0, done=0, pipeline valids flushed, accumulators keep partial values (don't-care).
  - Reset mid-sweep: immediate return to reset values.
  - vec wrap: the counter never wraps into a second pass; the SWEEP exit is decided on the terminal count.
- pass is registered at DRAIN exit; pass=0 outside DONE.

Decomposition:
- Package abs_diff_mon_pkg holds:
  - state enum {IDLE, SWEEP, DRAIN, DONE};
  - localparams N_VEC = 2**IN_W and DRAIN_CYC = 2;
  - a function exact_abs_diff(a, b).
- One sub-module, abs_diff_err_acc, contains:
  - S2 error computation;
  - max/sum/violation accumulators with a clear input.
- The top holds the FSM, the vector counter and the S0/S1 registers.

Test Plan:
- Exact |A-B| model as DUT, start pulse -> done at cycle 259; max_err=0, sum_err=0, viol_cnt=0, pass=1.
- Constant-0 DUT, ET=16 -> max_err=15, sum_err=1360, viol_cnt=0, pass=1. Same DUT with ET=7 -> viol_cnt=72, pass=0.
- Exact model with one corrupted vector (A=3, B=12 returns 0) -> max_err=9, sum_err=9, viol_cnt=0 at ET=16; viol_cnt=1 at ET=8.
- Abort at cycle 100 -> busy=0 and done=0 next cycle, dut_in frozen; new start gives full 259-cycle sweep with correct results.
- rst_n low at cycle 50 -> all outputs at reset values asynchronously; start during SWEEP ignored (done timing unchanged).
- Approximated netlist (ET=16 iteration) instantiated, sweep -> pass=1 and max_err<=16; check dut_in covers 0..255 exactly once, in order.
